// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-controlled single-word bus initiator.
// Receives 'W' addr data / 'R' addr frames on rx_i (8N1, LSB first) and issues
// one valid/ready transaction. Replies 'K' for a write or the 4 read-data bytes.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rx_i, tx_o        UART receive / transmit lines (idle high)
//   m_valid_o, m_ready_i, m_addr_o, m_wdata_o, m_we_o, m_rdata_i   bus master port
//   busy_o            high while the command FSM is not idle
module uart_bus_master #(
   parameter int unsigned CLKS_PER_BIT     = 868,
   parameter int unsigned TIMEOUT_CYCLES   = 1000000,
   localparam int unsigned RISCV_ADDR_WIDTH = 32,
   localparam int unsigned RISCV_WORD_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rx_i,
   output logic                        tx_o,
   output logic                        m_valid_o,
   input  logic                        m_ready_i,
   output logic [RISCV_ADDR_WIDTH-1:0] m_addr_o,
   output logic [RISCV_WORD_WIDTH-1:0] m_wdata_o,
   output logic [3:0]                  m_we_o,
   input  logic [RISCV_WORD_WIDTH-1:0] m_rdata_i,
   output logic                        busy_o
);

   localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]  CMD_WRITE = 8'h57;
   localparam logic [7:0]  CMD_READ  = 8'h52;
   localparam logic [7:0]  ACK_BYTE  = 8'h4B;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP} state_t;

   // ---------------- receiver ----------------
   rx_state_t        rx_state, rx_state_n;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]       rx_bit, rx_bit_n;
   logic [7:0]       rx_shift, rx_shift_n;
   logic             rx_valid, rx_valid_n;
   logic             rx_meta, rx_sync, rx_prev;

   // Synchronizer, edge history and receiver state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_meta  <= rx_i;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
         rx_valid <= rx_valid_n;
      end
   end

   // Receiver next state; rx_valid pulses the cycle after a good stop sample
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + 1'b1;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_valid_n = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            rx_bit_n = '0;
            if (rx_prev && !rx_sync) rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
               rx_cnt_n   = '0;
               rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_sync, rx_shift[7:1]};
               rx_bit_n   = rx_bit + 1'b1;
               if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               rx_state_n = RX_IDLE;
               rx_valid_n = rx_sync;   // low stop bit drops the byte
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // ---------------- command FSM ----------------
   state_t           state, state_n;
   logic             op_write;
   logic [1:0]       byte_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [23:0]      resp_q;
   logic [1:0]       resp_left;
   logic [8:0]       tx_shift;
   logic [3:0]       tx_bit;
   logic [CNT_W-1:0] tx_cnt;
   logic             timeout_c;
   logic             tx_done_c;

   assign timeout_c = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign tx_done_c = (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) && (tx_bit == 4'd9);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:
            if (rx_valid && (rx_shift == CMD_WRITE || rx_shift == CMD_READ)) state_n = ST_ADDR;
         ST_ADDR:
            if (rx_valid) begin
               if (byte_cnt == 2'd3) state_n = op_write ? ST_DATA : ST_BUS;
            end else if (timeout_c) state_n = ST_IDLE;
         ST_DATA:
            if (rx_valid) begin
               if (byte_cnt == 2'd3) state_n = ST_BUS;
            end else if (timeout_c) state_n = ST_IDLE;
         ST_BUS:
            if (m_ready_i) state_n = ST_RESP;
         ST_RESP:
            if (tx_done_c && resp_left == 2'd0) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Frame capture, bus outputs and response transmitter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_write  <= 1'b0;
         byte_cnt  <= '0;
         to_cnt    <= '0;
         resp_q    <= '0;
         resp_left <= '0;
         tx_shift  <= '1;
         tx_bit    <= '0;
         tx_cnt    <= '0;
         tx_o      <= 1'b1;
         m_valid_o <= 1'b0;
         m_we_o    <= 4'h0;
         m_addr_o  <= '0;
         m_wdata_o <= '0;
         busy_o    <= 1'b0;
      end else begin
         m_valid_o <= (state_n == ST_BUS);
         m_we_o    <= (state_n == ST_BUS && op_write) ? 4'hF : 4'h0;
         busy_o    <= (state_n != ST_IDLE);

         if (state == ST_IDLE && rx_valid) op_write <= (rx_shift == CMD_WRITE);

         if (state_n != state)
            byte_cnt <= '0;
         else if (rx_valid && (state == ST_ADDR || state == ST_DATA))
            byte_cnt <= byte_cnt + 1'b1;

         // Inactivity timer only runs while a frame is partially received
         if ((state == ST_ADDR || state == ST_DATA) && !rx_valid) to_cnt <= to_cnt + 1'b1;
         else                                                     to_cnt <= '0;

         // Little-endian fields land directly in the output registers; A0[1:0] forced to 0
         if (state == ST_ADDR && rx_valid)
            m_addr_o[{byte_cnt, 3'b000} +: 8] <= (byte_cnt == 2'd0) ? (rx_shift & 8'hFC) : rx_shift;
         if (state == ST_DATA && rx_valid)
            m_wdata_o[{byte_cnt, 3'b000} +: 8] <= rx_shift;

         // The accepting edge already starts the first start bit
         if (state == ST_BUS && m_ready_i) begin
            resp_q    <= op_write ? 24'h0 : m_rdata_i[31:8];
            resp_left <= op_write ? 2'd0 : 2'd3;
            tx_shift  <= {1'b1, (op_write ? ACK_BYTE : m_rdata_i[7:0])};
            tx_bit    <= '0;
            tx_cnt    <= '0;
            tx_o      <= 1'b0;
         end else if (state == ST_RESP) begin
            if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               tx_cnt <= '0;
               if (tx_bit == 4'd9) begin
                  if (resp_left != 2'd0) begin
                     resp_q    <= {8'h00, resp_q[23:8]};
                     resp_left <= resp_left - 1'b1;
                     tx_shift  <= {1'b1, resp_q[7:0]};
                     tx_bit    <= '0;
                     tx_o      <= 1'b0;
                  end
               end else begin
                  tx_o     <= tx_shift[0];
                  tx_shift <= {1'b1, tx_shift[8:1]};
                  tx_bit   <= tx_bit + 1'b1;
               end
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master: table of bus frames plus directed sequences
// for framing error, inter-byte timeout and reset during a response.
module tb_uart_bus_master;

   localparam int CPB     = 4;
   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_i;
   logic        tx_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [3:0]  m_we_o;
   logic [31:0] m_rdata_i;
   logic        busy_o;

   uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .tx_o(tx_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_we_o(m_we_o), .m_rdata_i(m_rdata_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit          is_write;
      bit          tie;
      bit          has_pre;
      logic [7:0]  pre;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          wait_cyc;
      logic [31:0] exp_addr;
      logic [3:0]  exp_we;
      logic [31:0] exp_wdata;
      int          exp_cycles;
      int          nresp;
      logic [31:0] exp_resp;
   } vec_t;

   // ---- bus monitor and ready driver ----
   bit          cur_tie = 1'b0;
   int          cur_wait = 0;
   int          burst_len = 0;
   int          valid_total = 0;
   int          unstable_total = 0;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_we;
   int unsigned valid_fall_cyc = 0;
   int unsigned busy_fall_cyc = 0;
   bit          prev_valid = 1'b0;
   bit          prev_busy = 1'b0;

   always @(negedge clk) begin
      if (m_valid_o === 1'b1) begin
         if (!prev_valid) begin
            burst_len = 0;
            cap_addr  = m_addr_o;
            cap_wdata = m_wdata_o;
            cap_we    = m_we_o;
         end else if (m_addr_o !== cap_addr || m_wdata_o !== cap_wdata || m_we_o !== cap_we) begin
            unstable_total++;
         end
         m_ready_i = cur_tie || (burst_len == cur_wait);
         burst_len++;
         valid_total++;
      end else begin
         m_ready_i = cur_tie;
         if (prev_valid) valid_fall_cyc = cyc;
      end
      if (prev_busy && busy_o !== 1'b1) busy_fall_cyc = cyc;
      prev_valid = (m_valid_o === 1'b1);
      prev_busy  = (busy_o === 1'b1);
   end

   // ---- UART TX decoder ----
   logic [7:0]  tx_bytes[$];
   int unsigned tx_starts[$];
   int          stop_err = 0;
   logic [7:0]  dec_b;
   int unsigned dec_s;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx_o === 1'b0) begin
            dec_s = cyc;
            repeat (2) @(negedge clk);
            if (tx_o === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  dec_b[i] = tx_o;
               end
               repeat (CPB) @(negedge clk);
               if (tx_o !== 1'b1) stop_err++;
               tx_bytes.push_back(dec_b);
               tx_starts.push_back(dec_s);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx_i = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx_i = stop_ok;
      repeat (CPB) @(posedge clk);
      #1;
      rx_i = 1'b1;
   endtask

   task automatic send_frame(input vec_t v);
      send_byte(v.is_write ? 8'h57 : 8'h52, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8], 1'b1);
      if (v.is_write)
         for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8], 1'b1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int vbase, ubase, tbase, ebase, got;
      cur_tie   = v.tie;
      cur_wait  = v.wait_cyc;
      m_rdata_i = v.rdata;
      vbase = valid_total; ubase = unstable_total; tbase = tx_bytes.size(); ebase = stop_err;
      if (v.has_pre) begin
         send_byte(v.pre, 1'b1);
         repeat (20) @(posedge clk);
         #1;
         check($sformatf("v%0d pre busy", idx), 32'(busy_o), 32'h0);
         check($sformatf("v%0d pre no bus", idx), 32'(valid_total - vbase), 32'h0);
         check($sformatf("v%0d pre no tx", idx), 32'(tx_bytes.size() - tbase), 32'h0);
      end
      send_frame(v);
      for (int n = 0; n < 60 * v.nresp + 200 && tx_bytes.size() < tbase + v.nresp; n++)
         @(posedge clk);
      for (int n = 0; n < 60 && busy_o !== 1'b0; n++) @(posedge clk);
      #1;
      got = tx_bytes.size() - tbase;
      check($sformatf("v%0d resp count", idx), 32'(got), 32'(v.nresp));
      check($sformatf("v%0d valid cycles", idx), 32'(valid_total - vbase), 32'(v.exp_cycles));
      check($sformatf("v%0d held stable", idx), 32'(unstable_total - ubase), 32'h0);
      check($sformatf("v%0d addr", idx), cap_addr, v.exp_addr);
      check($sformatf("v%0d we", idx), 32'(cap_we), 32'(v.exp_we));
      if (v.is_write) check($sformatf("v%0d wdata", idx), cap_wdata, v.exp_wdata);
      check($sformatf("v%0d stop bits", idx), 32'(stop_err - ebase), 32'h0);
      check($sformatf("v%0d busy idle", idx), 32'(busy_o), 32'h0);
      if (got >= v.nresp) begin
         for (int k = 0; k < v.nresp; k++) begin
            check($sformatf("v%0d tx byte %0d", idx, k), 32'(tx_bytes[tbase+k]), 32'(v.exp_resp[8*k +: 8]));
            if (k == 0)
               check($sformatf("v%0d tx start latency", idx), tx_starts[tbase], valid_fall_cyc);
            else
               check($sformatf("v%0d tx gap %0d", idx, k), tx_starts[tbase+k] - tx_starts[tbase+k-1], 32'(10 * CPB));
         end
         check($sformatf("v%0d busy fall", idx), busy_fall_cyc, tx_starts[tbase+v.nresp-1] + 32'(10 * CPB));
      end
      cur_tie = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   vec_t vecs[4];
   vec_t v_rst, v_post;
   int   vb, tb0;

   initial begin
      vecs[0] = '{is_write:1, tie:1, has_pre:0, pre:8'h00, addr:32'h0000_1000, wdata:32'hDEAD_BEEF,
                  rdata:32'h0, wait_cyc:0, exp_addr:32'h0000_1000, exp_we:4'hF, exp_wdata:32'hDEAD_BEEF,
                  exp_cycles:1, nresp:1, exp_resp:32'h0000_004B};
      vecs[1] = '{is_write:0, tie:0, has_pre:0, pre:8'h00, addr:32'h0000_2007, wdata:32'h0,
                  rdata:32'h1234_5678, wait_cyc:5, exp_addr:32'h0000_2004, exp_we:4'h0, exp_wdata:32'h0,
                  exp_cycles:6, nresp:4, exp_resp:32'h1234_5678};
      vecs[2] = '{is_write:0, tie:0, has_pre:1, pre:8'hAA, addr:32'h0000_0003, wdata:32'h0,
                  rdata:32'hCAFE_F00D, wait_cyc:0, exp_addr:32'h0000_0000, exp_we:4'h0, exp_wdata:32'h0,
                  exp_cycles:1, nresp:4, exp_resp:32'hCAFE_F00D};
      vecs[3] = '{is_write:1, tie:0, has_pre:0, pre:8'h00, addr:32'hFFFF_FFFF, wdata:32'h0403_0201,
                  rdata:32'h0, wait_cyc:2, exp_addr:32'hFFFF_FFFC, exp_we:4'hF, exp_wdata:32'h0403_0201,
                  exp_cycles:3, nresp:1, exp_resp:32'h0000_004B};
      v_rst   = '{is_write:0, tie:1, has_pre:0, pre:8'h00, addr:32'h0000_0040, wdata:32'h0,
                  rdata:32'hA5A5_5A5A, wait_cyc:0, exp_addr:32'h0000_0040, exp_we:4'h0, exp_wdata:32'h0,
                  exp_cycles:1, nresp:4, exp_resp:32'hA5A5_5A5A};
      v_post  = '{is_write:0, tie:0, has_pre:0, pre:8'h00, addr:32'h0000_0100, wdata:32'h0,
                  rdata:32'h0BAD_C0DE, wait_cyc:1, exp_addr:32'h0000_0100, exp_we:4'h0, exp_wdata:32'h0,
                  exp_cycles:2, nresp:4, exp_resp:32'h0BAD_C0DE};

      // Reset state
      rst_n = 1'b0; rx_i = 1'b1; m_rdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset tx", 32'(tx_o), 32'h1);
      check("reset valid", 32'(m_valid_o), 32'h0);
      check("reset busy", 32'(busy_o), 32'h0);
      check("reset we", 32'(m_we_o), 32'h0);
      check("reset addr", m_addr_o, 32'h0);
      check("reset wdata", m_wdata_o, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         repeat (5) @(posedge clk);
         #1;
         check($sformatf("post-reset quiet %0d", i), 32'({tx_o, m_valid_o, busy_o, m_we_o}), 32'h40);
      end

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Framing error: W with a low stop bit is dropped
      vb = valid_total; tb0 = tx_bytes.size();
      send_byte(8'h57, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      check("framing busy", 32'(busy_o), 32'h0);

      // Inter-byte timeout after two address bytes
      send_byte(8'h57, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("partial frame busy", 32'(busy_o), 32'h1);
      repeat (145) @(posedge clk);
      #1;
      check("before timeout busy", 32'(busy_o), 32'h1);
      repeat (100) @(posedge clk);
      #1;
      check("after timeout busy", 32'(busy_o), 32'h0);
      check("timeout no bus", 32'(valid_total - vb), 32'h0);
      check("timeout no tx", 32'(tx_bytes.size() - tb0), 32'h0);

      // Reset during the second response byte
      cur_tie = 1'b1; m_rdata_i = v_rst.rdata;
      tb0 = tx_bytes.size();
      send_frame(v_rst);
      for (int n = 0; n < 400 && tx_bytes.size() < tb0 + 1; n++) @(posedge clk);
      check("rst resp byte0 seen", 32'(tx_bytes.size() - tb0), 32'h1);
      if (tx_bytes.size() > tb0) check("rst resp byte0", 32'(tx_bytes[tb0]), 32'h5A);
      begin
         int n;
         for (n = 0; n < 60 && tx_o !== 1'b0; n++) @(negedge clk);
         check("second byte start seen", 32'(n < 60), 32'h1);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid-resp reset tx", 32'(tx_o), 32'h1);
      check("mid-resp reset busy", 32'(busy_o), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cur_tie = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("post-reset idle tx", 32'(tx_o), 32'h1);
      run_vec(v_post, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Host-controlled bus initiator for the RISC-V SoC. It receives framed read/write commands on a UART RX line and issues single-word transactions on a valid/ready memory bus as a master. It returns read data or a write acknowledge on UART TX. It sits beside `riscv_core` as a second initiator on the data bus (through an arbiter port) and is used for program loading and memory inspection without the core.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed inside a partial frame before it is discarded.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_i`  in  1  UART receive line, asynchronous, idle high.
- `tx_o`  out  1  UART transmit line, idle high.
- `m_valid_o`  out  1  bus request valid.
- `m_ready_i`  in  1  bus request accepted / read data valid.
- `m_addr_o`  out  `RISCV_ADDR_WIDTH`  byte address; bits [1:0] always 0.
- `m_wdata_o`  out  `RISCV_WORD_WIDTH`  write data.
- `m_we_o`  out  4  byte write enables: 4'hF for a write, 4'h0 for a read.
- `m_rdata_i`  in  `RISCV_WORD_WIDTH`  read data; sampled when `m_ready_i` is high.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
UART format:
- 8N1, LSB first.
- `rx_i` passes through a 2-flop synchronizer.
- A falling edge while the receiver is idle starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the event is a glitch and the receiver returns to idle.
- Data bits are sampled at mid-bit.
- A stop bit sampled low is a framing error: the byte is dropped and no FSM action occurs.

Frames (multi-byte fields little-endian):
- Write: 0x57 'W', A0..A3, D0..D3. Response: single byte 0x4B 'K'.
- Read: 0x52 'R', A0..A3. Response: R0..R3 (read word, LSB byte first).
- Any other command byte in IDLE is silently ignored.

Main FSM:
- IDLE: on a received byte 0x57 or 0x52, latch the op and go to ADDR.
- ADDR: shift in 4 bytes. Then go to DATA for a write, or to BUS for a read.
- DATA: shift in 4 bytes, then go to BUS.
- BUS: hold `m_valid_o`=1 with `m_addr_o`, `m_wdata_o`, `m_we_o` stable. On the first cycle with `m_ready_i`=1, capture `m_rdata_i` for a read and go to RESP.
- RESP: transmit 1 byte (write) or 4 bytes (read) back-to-back, then go to IDLE.

Frame and bus rules:
- The inter-byte timeout counter runs in ADDR/DATA and is cleared on each received byte. Reaching TIMEOUT_CYCLES returns the FSM to IDLE and sends nothing.
- Bytes received in BUS or RESP are discarded.
- The address register stores {A3,A2,A1,A0} with bits [1:0] cleared.
- There is no bus timeout: BUS waits indefinitely for `m_ready_i`.

## Timing
Reset values (while `rst_n`=0 at a clock edge):
- `tx_o`=1, `m_valid_o`=0, `m_addr_o`=0, `m_wdata_o`=0, `m_we_o`=0, `busy_o`=0.
- FSM and receiver go to IDLE; the transmitter goes idle.
- Reset mid-frame or mid-transmit aborts immediately. `tx_o` returns high on the next edge, even if that truncates a byte.

Latency:
- A byte is "received" on the cycle after the stop-bit mid-sample.
- `m_valid_o` rises 1 cycle after the final frame byte is received.
- On the cycle after `m_ready_i`=1 is sampled:
  - `m_valid_o`=0;
  - `m_we_o` returns to 0;
  - `tx_o` drives the first response start bit.
- If `m_ready_i` is already high in the first BUS cycle, the transaction takes exactly 1 cycle.
- TX byte duration is 10×CLKS_PER_BIT cycles. Consecutive response bytes have no idle gap.
- `busy_o` falls on the cycle after the last stop bit completes.

## Test plan
CLKS_PER_BIT=4 for all scenarios.
- Reset: hold `rst_n`=0 for 3 cycles -> `tx_o`=1, `m_valid_o`=0, `busy_o`=0. Release -> all outputs unchanged until the first RX byte.
- Write: send W, 00 10 00 00, EF BE AD DE with `m_ready_i` tied 1 -> exactly one cycle of `m_valid_o`=1 with addr=0x00001000, wdata=0xDEADBEEF, we=4'hF; then TX byte 0x4B.
- Read with wait states: send R, 07 20 00 00; `m_ready_i` low for 5 cycles, then high with rdata=0x12345678 -> addr=0x00002004, we=0; valid and addr held stable for all 6 cycles; TX bytes 78 56 34 12.
- Unaligned / garbage: send 0xAA, then R with address 03 00 00 00 -> 0xAA produces no activity; bus addr=0x00000000.
- Framing and timeout: send a W byte with its stop bit low -> ignored. Then send W, 2 address bytes, then silence for TIMEOUT_CYCLES -> `busy_o` drops; no bus request and no TX.
- Reset mid-response: assert `rst_n`=0 during the 2nd read response byte -> `tx_o`=1 on the next edge. After release, a new R frame completes normally.
